// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer, occupancy and flag controller for a 16x5 dual-address RAM
// Read data is captured one edge after an accepted pop and qualified by a one-cycle valid strobe.
module fifo_ctrl #(
  parameter int DATA_WIDTH = 5,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_rq,
  output logic                  mem_read_rq,
  output logic [ADDR_WIDTH-1:0] mem_w_address,
  output logic [ADDR_WIDTH-1:0] mem_r_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] L_AF    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] L_AE    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_fill_count;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid_out;
  logic                  r_overflow_err;
  logic                  r_underflow_err;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;

  assign w_full    = (r_fill_count == L_DEPTH);
  assign w_empty   = (r_fill_count == '0);
  assign w_pop_ok  = pop & ~w_empty;
  // A push at full is only safe when the same cycle frees the slot it overwrites.
  assign w_push_ok = push & (~w_full | w_pop_ok);

  assign mem_write_rq   = w_push_ok & ~rst;
  assign mem_read_rq    = w_pop_ok & ~rst;
  assign mem_w_address  = r_wr_ptr;
  assign mem_r_address  = r_rd_ptr;
  assign mem_write_data = data_in;

  assign data_out      = r_data_out;
  assign valid_out     = r_valid_out;
  assign fill_count    = r_fill_count;
  assign full          = w_full;
  assign empty         = w_empty;
  assign almost_full   = (r_fill_count >= L_AF);
  assign almost_empty  = (r_fill_count <= L_AE);
  assign overflow_err  = r_overflow_err;
  assign underflow_err = r_underflow_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_fill_count    <= '0;
      r_data_out      <= '0;
      r_valid_out     <= 1'b0;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_fill_count <= r_fill_count + (ADDR_WIDTH+1)'(1);
        2'b01:   r_fill_count <= r_fill_count - (ADDR_WIDTH+1)'(1);
        default: r_fill_count <= r_fill_count;
      endcase
      r_valid_out <= w_pop_ok;
      if (w_pop_ok) r_data_out <= mem_read_data;
      if (push & ~w_push_ok) r_overflow_err  <= 1'b1;
      if (pop & w_empty)     r_underflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed vector table plus corner-case sequences for fifo_ctrl
// A behavioural 16x5 RAM sits beside the controller so popped data can be checked end to end.
module tb_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       push;
  logic       pop;
  logic [4:0] data_in;
  logic [4:0] mem_read_data;
  logic       mem_write_rq;
  logic       mem_read_rq;
  logic [3:0] mem_w_address;
  logic [3:0] mem_r_address;
  logic [4:0] mem_write_data;
  logic [4:0] data_out;
  logic       valid_out;
  logic [4:0] fill_count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow_err;
  logic       underflow_err;

  fifo_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .pop            (pop),
    .data_in        (data_in),
    .mem_read_data  (mem_read_data),
    .mem_write_rq   (mem_write_rq),
    .mem_read_rq    (mem_read_rq),
    .mem_w_address  (mem_w_address),
    .mem_r_address  (mem_r_address),
    .mem_write_data (mem_write_data),
    .data_out       (data_out),
    .valid_out      (valid_out),
    .fill_count     (fill_count),
    .full           (full),
    .empty          (empty),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty),
    .overflow_err   (overflow_err),
    .underflow_err  (underflow_err)
  );

  logic [4:0] ram [16];
  always @(posedge clk) if (mem_write_rq) ram[mem_w_address] <= mem_write_data;
  assign mem_read_data = ram[mem_r_address];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rst, push, pop;
    logic [4:0] din;
    logic       wrq, rrq;
    logic [3:0] wa, ra;
    logic [4:0] fill;
    logic       vld;
    logic [4:0] dout;
    logic       ovf, unf;
  } vec_t;

  vec_t       vecs [14];
  logic [4:0] q [$];
  logic [4:0] w;
  logic [4:0] last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_flags(input logic [4:0] f);
    return {f == 5'd16, f == 5'd0, f >= 5'd12, f <= 5'd2};
  endfunction

  task automatic drive(input logic r, input logic p, input logic o, input logic [4:0] d);
    rst = r; push = p; pop = o; data_in = d;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0;
    tick();
    tick();

    //        rst  push pop  din    wrq  rrq  wa     ra     fill   vld  dout   ovf  unf
    vecs[0]  = '{1'b1,1'b1,1'b1,5'h03, 1'b0,1'b0,4'd0,4'd0, 5'd0,1'b0,5'h00,1'b0,1'b0};
    vecs[1]  = '{1'b0,1'b1,1'b0,5'h01, 1'b1,1'b0,4'd0,4'd0, 5'd1,1'b0,5'h00,1'b0,1'b0};
    vecs[2]  = '{1'b0,1'b1,1'b0,5'h02, 1'b1,1'b0,4'd1,4'd0, 5'd2,1'b0,5'h00,1'b0,1'b0};
    vecs[3]  = '{1'b0,1'b1,1'b0,5'h03, 1'b1,1'b0,4'd2,4'd0, 5'd3,1'b0,5'h00,1'b0,1'b0};
    vecs[4]  = '{1'b0,1'b1,1'b0,5'h04, 1'b1,1'b0,4'd3,4'd0, 5'd4,1'b0,5'h00,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b1,1'b0,5'h05, 1'b1,1'b0,4'd4,4'd0, 5'd5,1'b0,5'h00,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,1'b1,5'h00, 1'b0,1'b1,4'd5,4'd0, 5'd4,1'b1,5'h01,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,1'b0,5'h00, 1'b0,1'b0,4'd5,4'd1, 5'd4,1'b0,5'h01,1'b0,1'b0};
    vecs[8]  = '{1'b0,1'b1,1'b1,5'h06, 1'b1,1'b1,4'd5,4'd1, 5'd4,1'b1,5'h02,1'b0,1'b0};
    vecs[9]  = '{1'b1,1'b1,1'b0,5'h09, 1'b0,1'b0,4'd6,4'd2, 5'd0,1'b0,5'h00,1'b0,1'b0};
    vecs[10] = '{1'b0,1'b0,1'b1,5'h00, 1'b0,1'b0,4'd0,4'd0, 5'd0,1'b0,5'h00,1'b0,1'b1};
    vecs[11] = '{1'b0,1'b1,1'b1,5'h07, 1'b1,1'b0,4'd0,4'd0, 5'd1,1'b0,5'h00,1'b0,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b1,5'h00, 1'b0,1'b1,4'd1,4'd0, 5'd0,1'b1,5'h07,1'b0,1'b1};
    vecs[13] = '{1'b1,1'b0,1'b0,5'h00, 1'b0,1'b0,4'd1,4'd1, 5'd0,1'b0,5'h00,1'b0,1'b0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].din);
      chk($sformatf("vec%0d ram_drive", i),
          {mem_write_rq, mem_read_rq, mem_w_address, mem_r_address},
          {vecs[i].wrq, vecs[i].rrq, vecs[i].wa, vecs[i].ra});
      tick();
      chk($sformatf("vec%0d fill_count", i), fill_count, vecs[i].fill);
      chk($sformatf("vec%0d flags", i), {full, empty, almost_full, almost_empty},
          exp_flags(vecs[i].fill));
      chk($sformatf("vec%0d valid/data", i), {valid_out, data_out}, {vecs[i].vld, vecs[i].dout});
      chk($sformatf("vec%0d errors", i), {overflow_err, underflow_err}, {vecs[i].ovf, vecs[i].unf});
    end

    // Fill to DEPTH, then push+pop at full on the shared address.
    for (int i = 0; i < 16; i++) begin
      w = 5'((i * 7 + 3) % 32);
      drive(1'b0, 1'b1, 1'b0, w);
      q.push_back(w);
      tick();
    end
    chk("fill16 count", fill_count, 32'd16);
    chk("fill16 flags", {full, empty, almost_full, almost_empty}, 4'b1010);

    drive(1'b0, 1'b1, 1'b1, 5'h0A);
    chk("full push_pop drive", {mem_write_rq, mem_read_rq, mem_w_address, mem_r_address},
        {1'b1, 1'b1, 4'd0, 4'd0});
    tick();
    w = q.pop_front();
    q.push_back(5'h0A);
    chk("full push_pop data", {valid_out, data_out}, {1'b1, w});
    chk("full push_pop count", fill_count, 32'd16);
    chk("full push_pop no_ovf", overflow_err, 1'b0);
    chk("full push_pop ptrs", {mem_w_address, mem_r_address}, {4'd1, 4'd1});

    drive(1'b0, 1'b1, 1'b0, 5'h1F);
    chk("overflow no_write", mem_write_rq, 1'b0);
    tick();
    chk("overflow err", overflow_err, 1'b1);
    chk("overflow count", fill_count, 32'd16);
    chk("overflow wr_ptr", mem_w_address, 4'd1);

    last = '0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b1, 5'h00);
      tick();
      last = q.pop_front();
      chk($sformatf("drain%0d", i), {valid_out, data_out}, {1'b1, last});
    end
    drive(1'b0, 1'b0, 1'b0, 5'h00);
    tick();
    chk("drained hold", {valid_out, data_out}, {1'b0, last});
    chk("drained flags", {full, empty, almost_full, almost_empty}, 4'b0101);
    chk("drained errors sticky", {overflow_err, underflow_err}, 2'b10);

    // Reset mid-operation at fill_count 9 with push and pop requested.
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, 1'b1, 1'b0, 5'(i + 16));
      tick();
    end
    chk("fill9 count", fill_count, 32'd9);
    drive(1'b1, 1'b1, 1'b1, 5'h15);
    chk("rst ram_rq low", {mem_write_rq, mem_read_rq}, 2'b00);
    tick();
    drive(1'b0, 1'b0, 1'b0, 5'h00);
    chk("rst count", fill_count, 32'd0);
    chk("rst flags", {full, empty, almost_full, almost_empty}, 4'b0101);
    chk("rst errors", {overflow_err, underflow_err}, 2'b00);
    chk("rst valid/data", {valid_out, data_out}, 6'd0);
    chk("rst ptrs", {mem_w_address, mem_r_address}, 8'd0);

    // Interleaved push/pop across the 15->0 pointer wrap.
    for (int k = 0; k < 20; k++) begin
      w = 5'((k + 11) % 32);
      drive(1'b0, 1'b1, 1'b0, w);
      chk($sformatf("wrap%0d w_addr", k), {mem_write_rq, mem_w_address}, {1'b1, 4'(k % 16)});
      tick();
      chk($sformatf("wrap%0d flags_after_push", k), {almost_full, almost_empty, fill_count},
          {1'b0, 1'b1, 5'd1});
      drive(1'b0, 1'b0, 1'b1, 5'h00);
      chk($sformatf("wrap%0d r_addr", k), {mem_read_rq, mem_r_address}, {1'b1, 4'(k % 16)});
      tick();
      chk($sformatf("wrap%0d data", k), {valid_out, data_out}, {1'b1, w});
      chk($sformatf("wrap%0d flags_after_pop", k), {almost_full, almost_empty, empty},
          3'b011);
    end
    drive(1'b0, 1'b0, 1'b0, 5'h00);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller that sits directly upstream of the 16x5 dual-address RAM.
- Turns a push/pop handshake into the RAM's write_rq/read_rq, w_address/r_address and write_data signals.
- Registers the RAM's read data onto a valid-qualified output and tracks occupancy.
- Provides full/empty/almost flags and sticky overflow/underflow errors for the downstream flow-control logic.

Parameters:
- DATA_WIDTH, 5, width of each stored word.
- ADDR_WIDTH, 4, RAM address width.
- DEPTH, 16, number of RAM entries; must equal 2**ADDR_WIDTH.
- AF_THRESH, 12, almost_full asserts when fill_count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when fill_count <= AE_THRESH.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  write request from upstream.
- pop  in  1  read request from downstream.
- data_in  in  DATA_WIDTH  word to store on an accepted push.
- mem_read_data  in  DATA_WIDTH  combinational read data returned by the RAM.
- mem_write_rq  out  1  RAM write request.
- mem_read_rq  out  1  RAM read request.
- mem_w_address  out  ADDR_WIDTH  RAM write address, equal to wr_ptr.
- mem_r_address  out  ADDR_WIDTH  RAM read address, equal to rd_ptr.
- mem_write_data  out  DATA_WIDTH  equals data_in.
- data_out  out  DATA_WIDTH  registered popped word.
- valid_out  out  1  one-cycle strobe qualifying data_out.
- fill_count  out  ADDR_WIDTH+1  occupancy, range 0..DEPTH.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- overflow_err, underflow_err  out  1 each  sticky error flags.

Behaviour:
- Acceptance rules:
  - pop_ok = pop & !empty.
  - push_ok = push & (!full | pop_ok). A push at full is accepted only when a simultaneous pop is accepted.
  - A push at empty with a simultaneous pop: the push is accepted, the pop is rejected and counts as underflow.
- RAM drive (combinational):
  - mem_write_rq = push_ok & !rst; mem_read_rq = pop_ok & !rst.
  - mem_w_address = wr_ptr; mem_r_address = rd_ptr; mem_write_data = data_in.
- Pointers:
  - wr_ptr increments on push_ok; rd_ptr increments on pop_ok.
  - Both are ADDR_WIDTH bits and wrap naturally from 15 to 0.
- fill_count update:
  - +1 on push_ok only; -1 on pop_ok only; unchanged when both or neither.
  - Never leaves the range 0..DEPTH.
- Flags, combinational from the registered fill_count:
  - full = (fill_count == DEPTH); empty = (fill_count == 0).
  - almost_full = (fill_count >= AF_THRESH); almost_empty = (fill_count <= AE_THRESH).
- Read latency:
  - On pop_ok in cycle N, mem_read_data (the RAM's stored word at rd_ptr) is captured into data_out at the edge ending cycle N.
  - valid_out is high for cycle N+1 only. Back-to-back pops give back-to-back valid_out.
  - data_out holds its last value when valid_out is low.
- Simultaneous push and pop at full (same address, wr_ptr == rd_ptr):
  - The read returns the old stored word; the new word is written at the edge.
  - fill_count stays at DEPTH.
- Errors (sticky until rst):
  - overflow_err sets when push & !push_ok.
  - underflow_err sets when pop & empty.
  - A rejected operation does not move its pointer or change fill_count.
- Reset, including mid-operation:
  - On any edge with rst=1, all registered state clears: wr_ptr=0, rd_ptr=0, fill_count=0, data_out=0, valid_out=0, overflow_err=0, underflow_err=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - RAM requests are forced low while rst=1.
  - RAM contents are not cleared by this block.
  - Push/pop requests in the same cycle as rst are ignored.

Test Plan:
- Reset, then push 0x01..0x05 on consecutive cycles -> fill_count=5, wr_ptr=5, empty=0, almost_empty=0; mem_w_address steps 0..4 with mem_write_rq=1.
- Fill to 16 then push 0x1F -> full=1, overflow_err=1, fill_count stays 16, wr_ptr stays 0; pop 16 times -> data_out sequence matches the pushed words, valid_out 16 consecutive cycles, empty=1.
- At fill_count=16, push 0x0A with a simultaneous pop -> data_out equals the oldest word one cycle later, fill_count=16, no overflow; both pointers advance by 1.
- On empty, pop with a simultaneous push of 0x07 -> underflow_err=1, valid_out stays 0, fill_count=1; next-cycle pop -> data_out=0x07, valid_out=1.
- Pointer wrap: push 20 and pop 20 interleaved with fill_count never >2 -> pointers wrap 15->0 and data order is preserved; almost_full never asserts; almost_empty stays high.
- Assert rst for 1 cycle at fill_count=9 during a push/pop -> next cycle fill_count=0, empty=1, errors=0, valid_out=0; mem_write_rq and mem_read_rq were 0 during the reset cycle.
